// File: rtl/csa_pkg.sv
// ============================================================================
// Module   : csa_pkg
// Purpose  : Shared FSM encoding and default operand/chunk widths for the
//            carry-save tree and its resolver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

    localparam int CSA_WIDTH = 2048;
    localparam int CSA_CHUNK = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cpa_chunk.sv
// ============================================================================
// Module   : cpa_chunk
// Purpose  : Purely combinational CHUNK-bit carry-propagate adder slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpa_chunk #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/csa_resolver.sv
// ============================================================================
// Module   : csa_resolver
// Purpose  : Resolves a carry-save pair into s + (c << 1), one CHUNK slice per
//            clock. Define CSA_RESOLVER_OVF_EN to add the ovf output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] s_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum
`ifdef CSA_RESOLVER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDXW  = (N > 1) ? $clog2(N) : 1;
    localparam int BASEW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(N - 1);

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [WIDTH+1:0]   sum_q, sum_d;

    logic [WIDTH-1:0]   w_cshift;
    logic [BASEW-1:0]   w_base;
    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic [CHUNK-1:0]   w_chunk_s;
    logic               w_chunk_cout;

    // Carry bit i carries weight 2^(i+1); its top bit is folded in at the end.
    assign w_cshift  = {c_q[WIDTH-2:0], 1'b0};
    assign w_base    = BASEW'(int'(idx_q) * CHUNK);
    assign w_chunk_a = s_q[w_base +: CHUNK];
    assign w_chunk_b = w_cshift[w_base +: CHUNK];

    cpa_chunk #(
        .CHUNK (CHUNK)
    ) u_cpa_chunk (
        .a    (w_chunk_a),
        .b    (w_chunk_b),
        .cin  (carry_q),
        .s    (w_chunk_s),
        .cout (w_chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c_d     = c_q;
        s_d     = s_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c_d     = c_in;
                    s_d     = s_in;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[w_base +: CHUNK] = w_chunk_s;
                carry_d = w_chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == C_LAST_IDX) begin
                    sum_d[WIDTH+1:WIDTH] = {1'b0, c_q[WIDTH-1]} + {1'b0, w_chunk_cout};
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;

`ifdef CSA_RESOLVER_OVF_EN
    assign ovf = (sum_q[WIDTH+1:WIDTH] != 2'b00);
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_resolver.sv
// ============================================================================
// Module   : tb_csa_resolver
// Purpose  : Directed self-checking bench for csa_resolver (default widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_resolver;

    localparam int W  = 2048;
    localparam int CH = 64;
    localparam int N  = W / CH;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   c_in;
    logic [W-1:0]   s_in;
    logic           out_valid;
    logic           out_ready;
    logic [W+1:0]   sum;
`ifdef CSA_RESOLVER_OVF_EN
    logic           ovf;
`endif

    int n_cmp;
    int n_err;

    csa_resolver #(
        .WIDTH (W),
        .CHUNK (CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef CSA_RESOLVER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
                     tag, got[W+1:W-62], got[63:0], exp[W+1:W-62], exp[63:0]);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns just after the accept edge.
    task automatic start_op(input logic [W-1:0] c, input logic [W-1:0] s);
        chk("in_ready_before_accept", in_ready, 1);
        c_in     = c;
        s_in     = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c_in     = '0;
        s_in     = '0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 4 * N) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, N);
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_dropped"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] exp);
        chk({tag, "_sum"}, sum, exp);
`ifdef CSA_RESOLVER_OVF_EN
        chk({tag, "_ovf"}, ovf, (exp[W+1:W] != 2'b00));
`endif
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] c,
                            input logic [W-1:0] s, input logic [W+1:0] exp);
        start_op(c, s);
        wait_done(tag);
        check_result(tag, exp);
        take(tag);
    endtask

    logic [W-1:0]   ones;
    logic [W-1:0]   one;
    logic [W-1:0]   pat_a;
    logic [W-1:0]   pat_b;
    logic [W+1:0]   exp;
    logic [W+1:0]   held;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c_in      = '0;
        s_in      = '0;
        ones      = '1;
        one       = '0;
        one[0]    = 1'b1;
        pat_a     = {(W/64){64'hA5A5_F00F_1234_8765}};
        pat_b     = {(W/64){64'h5A5A_0FF0_FEDC_789A}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, '0);

        // First accept on the first edge after release.
        rst_n = 1'b1;
        exp = '0;
        exp[15:0] = 16'h1234;
        run_case("small", '0, W'(16'h1234), exp);

        exp = '0;
        exp[W] = 1'b1;
        exp[0] = 1'b1;
        run_case("s_ones_c_one", one, ones, exp);

        // 3*2^W - 3 = binary 10 followed by (W-2) ones then 01
        exp = {2'b10, {(W-2){1'b1}}, 2'b01};
        run_case("all_ones", ones, ones, exp);

        exp = {2'b00, pat_a} + {1'b0, pat_b, 1'b0};
        run_case("mixed", pat_b, pat_a, exp);

        // in_valid during RUN must be ignored
        exp = {2'b00, pat_b} + {1'b0, pat_a, 1'b0};
        start_op(pat_a, pat_b);
        repeat (3) @(posedge clk);
        #1;
        c_in = ones; s_in = ones; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; c_in = '0; s_in = '0;
        while (!out_valid && n_cmp < 100000) begin
            @(posedge clk); #1;
        end
        check_result("run_pulse", exp);

        // Stall in DONE for 10 cycles with an in_valid pulse in the middle.
        held = sum;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                c_in = ones; s_in = one; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("stall_sum", sum, exp);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        in_valid = 1'b0; c_in = '0; s_in = '0;
        chk("stall_held", sum, held);
        take("stall");
        repeat (N + 2) @(posedge clk);
        #1;
        chk("pulse_ignored_valid", out_valid, 0);
        chk("pulse_ignored_ready", in_ready, 1);

        // Abort in RUN cycle 5.
        start_op(ones, ones);
        repeat (4) @(posedge clk);
        #2;
        chk("abort_pre_running", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_sum", sum, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp = {2'b00, pat_a} + {1'b0, one, 1'b0};
        run_case("after_abort", one, pat_a, exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit hit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
